// File: rtl/spi_slave_acl.sv
// SPI mode-0 responder that mimics the ADXL362 register interface on the CLK100MHZ domain.
// It serves ID and snapshotted XYZ registers, and implements POWER_CTL and SOFT_RESET.
module spi_slave_acl #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEVID_AD    = 8'hAD,
    parameter logic [7:0] DEVID_MST   = 8'h1D,
    parameter logic [7:0] PARTID      = 8'hF2
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [11:0] x_data,
    input  logic [11:0] y_data,
    input  logic [11:0] z_data,
    output logic [7:0]  power_ctl,
    output logic        txn_done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_RDATA  = 3'd3,
        ST_WDATA  = 3'd4,
        ST_IGNORE = 3'd5
    } state_t;

    localparam logic [7:0] CMD_READ    = 8'h0B;
    localparam logic [7:0] CMD_WRITE   = 8'h0A;
    localparam logic [7:0] ADDR_PWRCTL = 8'h2D;
    localparam logic [7:0] ADDR_SRST   = 8'h1F;
    localparam logic [7:0] SRST_KEY    = 8'h52;

    // Register read map; anything unmapped (including SOFT_RESET) reads zero.
    function automatic logic [7:0] read_reg(
        input logic [7:0]  a,
        input logic [11:0] xs,
        input logic [11:0] ys,
        input logic [11:0] zs,
        input logic [7:0]  pc
    );
        logic [7:0] v;
        case (a)
            8'h00:   v = DEVID_AD;
            8'h01:   v = DEVID_MST;
            8'h02:   v = PARTID;
            8'h08:   v = xs[11:4];
            8'h09:   v = ys[11:4];
            8'h0A:   v = zs[11:4];
            8'h0E:   v = xs[7:0];
            8'h0F:   v = {{4{xs[11]}}, xs[11:8]};
            8'h10:   v = ys[7:0];
            8'h11:   v = {{4{ys[11]}}, ys[11:8]};
            8'h12:   v = zs[7:0];
            8'h13:   v = {{4{zs[11]}}, zs[11:8]};
            8'h2D:   v = pc;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic        sclk_prev_q, sclk_prev_d;
    logic        cs_prev_q, cs_prev_d;
    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  addr_q, addr_d;
    logic        rd_q, rd_d;
    logic        data_done_q, data_done_d;
    logic [11:0] x_snap_q, x_snap_d;
    logic [11:0] y_snap_q, y_snap_d;
    logic [11:0] z_snap_q, z_snap_d;
    logic        miso_q, miso_d;
    logic        miso_oe_q, miso_oe_d;
    logic [7:0]  power_ctl_q, power_ctl_d;
    logic        txn_done_q, txn_done_d;

    logic        sclk_s, cs_s, mosi_s;
    logic        sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s, last_bit_s;
    logic [7:0]  rx_byte_s, rd_byte_s;

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_prev_q;
    assign sclk_fall_s = ~sclk_s & sclk_prev_q;
    assign cs_rise_s   = cs_s & ~cs_prev_q;
    assign cs_fall_s   = ~cs_s & cs_prev_q;
    assign last_bit_s  = (bit_cnt_q == 3'd7);
    assign rx_byte_s   = {shift_q[6:0], mosi_s};
    assign rd_byte_s   = read_reg(addr_q, x_snap_q, y_snap_q, z_snap_q, power_ctl_q);

    // Next-state logic: synchronizers, frame FSM, shift registers and register file.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        data_done_d = data_done_q;
        x_snap_d    = x_snap_q;
        y_snap_d    = y_snap_q;
        z_snap_d    = z_snap_q;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        power_ctl_d = power_ctl_q;
        txn_done_d  = 1'b0;

        if ((state_q != ST_IDLE) && cs_rise_s) begin
            // Frame end wins over any sclk edge; partial bytes simply vanish.
            state_d     = ST_IDLE;
            bit_cnt_d   = 3'd0;
            shift_d     = 8'h00;
            tx_d        = 8'h00;
            miso_d      = 1'b0;
            miso_oe_d   = 1'b0;
            txn_done_d  = data_done_q;
            data_done_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        state_d     = ST_CMD;
                        bit_cnt_d   = 3'd0;
                        shift_d     = 8'h00;
                        data_done_d = 1'b0;
                        x_snap_d    = x_data;
                        y_snap_d    = y_data;
                        z_snap_d    = z_data;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise_s) begin
                        shift_d   = rx_byte_s;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit_s) begin
                            if (rx_byte_s == CMD_READ) begin
                                rd_d    = 1'b1;
                                state_d = ST_ADDR;
                            end else if (rx_byte_s == CMD_WRITE) begin
                                rd_d    = 1'b0;
                                state_d = ST_ADDR;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end else begin
                            state_d = ST_CMD;
                        end
                    end else begin
                        state_d = ST_CMD;
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise_s) begin
                        shift_d   = rx_byte_s;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit_s) begin
                            addr_d  = rx_byte_s;
                            state_d = rd_q ? ST_RDATA : ST_WDATA;
                        end else begin
                            state_d = ST_ADDR;
                        end
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
                ST_RDATA: begin
                    // The pointer advances at the byte's 8th rise, so the next fall loads the new byte.
                    if (sclk_rise_s) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit_s) begin
                            addr_d      = addr_q + 8'd1;
                            data_done_d = 1'b1;
                        end else begin
                            addr_d = addr_q;
                        end
                    end else if (sclk_fall_s) begin
                        miso_oe_d = 1'b1;
                        if (bit_cnt_q == 3'd0) begin
                            miso_d = rd_byte_s[7];
                            tx_d   = {rd_byte_s[6:0], 1'b0};
                        end else begin
                            miso_d = tx_q[7];
                            tx_d   = {tx_q[6:0], 1'b0};
                        end
                    end else begin
                        tx_d = tx_q;
                    end
                end
                ST_WDATA: begin
                    if (sclk_rise_s) begin
                        shift_d   = rx_byte_s;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit_s) begin
                            if (addr_q == ADDR_PWRCTL) begin
                                power_ctl_d = rx_byte_s;
                            end else if ((addr_q == ADDR_SRST) && (rx_byte_s == SRST_KEY)) begin
                                power_ctl_d = 8'h00;
                            end else begin
                                power_ctl_d = power_ctl_q;
                            end
                            addr_d      = addr_q + 8'd1;
                            data_done_d = 1'b1;
                        end else begin
                            addr_d = addr_q;
                        end
                    end else begin
                        shift_d = shift_q;
                    end
                end
                ST_IGNORE: begin
                    state_d = ST_IGNORE;
                end
                default: begin
                    state_d   = ST_IDLE;
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State registers; cs_n sync resets low so a frame only starts after cs_n is seen high.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            tx_q        <= 8'h00;
            addr_q      <= 8'h00;
            rd_q        <= 1'b0;
            data_done_q <= 1'b0;
            x_snap_q    <= 12'h000;
            y_snap_q    <= 12'h000;
            z_snap_q    <= 12'h000;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            power_ctl_q <= 8'h00;
            txn_done_q  <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            data_done_q <= data_done_d;
            x_snap_q    <= x_snap_d;
            y_snap_q    <= y_snap_d;
            z_snap_q    <= z_snap_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            power_ctl_q <= power_ctl_d;
            txn_done_q  <= txn_done_d;
        end
    end

    assign miso      = miso_q & miso_oe_q;
    assign miso_oe   = miso_oe_q;
    assign power_ctl = power_ctl_q;
    assign txn_done  = txn_done_q;

endmodule

// File: tb/tb_spi_slave_acl.sv
// Self-checking bench for spi_slave_acl: an SPI mode-0 master model with a
// queue of expected read bytes that is consumed as bytes come back on miso.
module tb_spi_slave_acl;

    localparam int HALF = 8;

    logic        clk;
    logic        rst_n;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic [11:0] x_data;
    logic [11:0] y_data;
    logic [11:0] z_data;
    logic [7:0]  power_ctl;
    logic        txn_done;

    int n_cmp  = 0;
    int n_fail = 0;
    int txn_cnt = 0;
    int oe_cnt  = 0;
    logic [7:0] exp_q[$];

    spi_slave_acl dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .x_data    (x_data),
        .y_data    (y_data),
        .z_data    (z_data),
        .power_ctl (power_ctl),
        .txn_done  (txn_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count txn_done pulse cycles and miso_oe-high cycles.
    always @(negedge clk) begin
        if (txn_done) txn_cnt++;
        if (miso_oe) oe_cnt++;
    end

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx, output logic oe_all);
        rx = 8'h00;
        oe_all = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            repeat (HALF) @(negedge clk);
            rx = {rx[6:0], miso};
            oe_all = oe_all & miso_oe;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic check_byte(input string name, input logic [7:0] rx, input logic oe);
        logic [7:0] exp;
        exp = exp_q.pop_front();
        n_cmp++;
        if (rx !== exp || oe !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got %h (oe=%b) expected %h (oe=1)", name, rx, oe, exp);
        end
    endtask

    task automatic do_read(input string name, input logic [7:0] addr, input int n);
        logic [7:0] rx;
        logic oe;
        int t0;
        t0 = txn_cnt;
        cs_low();
        xfer(8'h0B, 8, rx, oe);
        xfer(addr, 8, rx, oe);
        for (int k = 0; k < n; k++) begin
            xfer(8'h00, 8, rx, oe);
            check_byte(name, rx, oe);
        end
        cs_high();
        n_cmp++;
        if (txn_cnt - t0 !== 1) begin
            n_fail++;
            $display("FAIL %s_txn: got %0d pulses expected 1", name, txn_cnt - t0);
        end
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
        logic [7:0] rx;
        logic oe;
        cs_low();
        xfer(8'h0A, 8, rx, oe);
        xfer(addr, 8, rx, oe);
        xfer(data, 8, rx, oe);
        cs_high();
    endtask

    task automatic check_outputs_reset(input string name);
        n_cmp++;
        if (miso !== 1'b0 || miso_oe !== 1'b0 || power_ctl !== 8'h00 || txn_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got miso=%b oe=%b pc=%h done=%b expected 0 0 00 0",
                     name, miso, miso_oe, power_ctl, txn_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check_outputs_reset("reset_held");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_outputs_reset("reset_released");
    endtask

    task automatic test_id_read();
        exp_q.push_back(8'hAD);
        exp_q.push_back(8'h1D);
        exp_q.push_back(8'hF2);
        do_read("id_read", 8'h00, 3);
    endtask

    task automatic test_xyz_burst();
        x_data = 12'h7FF;
        y_data = 12'h800;
        z_data = 12'h001;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hF8);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h00);
        do_read("xyz_burst", 8'h0E, 6);
    endtask

    task automatic test_write();
        do_write(8'h2D, 8'h02);
        n_cmp++;
        if (power_ctl !== 8'h02) begin
            n_fail++;
            $display("FAIL write_pwrctl: got %h expected 02", power_ctl);
        end
        exp_q.push_back(8'h02);
        do_read("pwrctl_readback", 8'h2D, 1);
        do_write(8'h1F, 8'h11);
        n_cmp++;
        if (power_ctl !== 8'h02) begin
            n_fail++;
            $display("FAIL srst_wrong_key: got %h expected 02", power_ctl);
        end
        do_write(8'h1F, 8'h52);
        n_cmp++;
        if (power_ctl !== 8'h00) begin
            n_fail++;
            $display("FAIL srst_key: got %h expected 00", power_ctl);
        end
    endtask

    task automatic test_snapshot();
        logic [7:0] rx;
        logic oe;
        x_data = 12'h123;
        y_data = 12'h456;
        z_data = 12'h789;
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h45);
        exp_q.push_back(8'h78);
        cs_low();
        x_data = 12'hABC;
        xfer(8'h0B, 8, rx, oe);
        xfer(8'h08, 8, rx, oe);
        xfer(8'h00, 8, rx, oe);
        check_byte("snap_x", rx, oe);
        y_data = 12'hDEF;
        z_data = 12'h111;
        xfer(8'h00, 8, rx, oe);
        check_byte("snap_y", rx, oe);
        xfer(8'h00, 8, rx, oe);
        check_byte("snap_z", rx, oe);
        cs_high();
    endtask

    task automatic test_abort_and_ignore();
        logic [7:0] rx;
        logic oe;
        int t0;
        int o0;
        t0 = txn_cnt;
        cs_low();
        xfer(8'h0A, 8, rx, oe);
        xfer(8'h2D, 8, rx, oe);
        xfer(8'hFF, 5, rx, oe);
        cs_high();
        n_cmp++;
        if (power_ctl !== 8'h00 || txn_cnt - t0 !== 0) begin
            n_fail++;
            $display("FAIL partial_write: got pc=%h pulses=%0d expected 00 0", power_ctl, txn_cnt - t0);
        end
        o0 = oe_cnt;
        t0 = txn_cnt;
        cs_low();
        xfer(8'h55, 8, rx, oe);
        xfer(8'h00, 8, rx, oe);
        xfer(8'h00, 8, rx, oe);
        cs_high();
        n_cmp++;
        if (oe_cnt - o0 !== 0 || txn_cnt - t0 !== 0) begin
            n_fail++;
            $display("FAIL bad_cmd: got oe_cycles=%0d pulses=%0d expected 0 0", oe_cnt - o0, txn_cnt - t0);
        end
    endtask

    task automatic test_wrap();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hAD);
        do_read("wrap", 8'hFF, 2);
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        logic oe;
        int t0;
        int o0;
        do_write(8'h2D, 8'h0A);
        cs_low();
        xfer(8'h0B, 8, rx, oe);
        xfer(8'h00, 8, rx, oe);
        xfer(8'h00, 4, rx, oe);
        n_cmp++;
        if (oe !== 1'b1 || rx !== 8'h0A) begin
            n_fail++;
            $display("FAIL mid_partial: got rx=%h oe=%b expected 0a 1", rx, oe);
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_reset("mid_reset");
        rst_n = 1'b1;
        t0 = txn_cnt;
        o0 = oe_cnt;
        xfer(8'h0B, 8, rx, oe);
        xfer(8'h00, 8, rx, oe);
        xfer(8'h00, 8, rx, oe);
        cs_high();
        n_cmp++;
        if (oe_cnt - o0 !== 0 || txn_cnt - t0 !== 0) begin
            n_fail++;
            $display("FAIL no_midframe_start: got oe_cycles=%0d pulses=%0d expected 0 0", oe_cnt - o0, txn_cnt - t0);
        end
        exp_q.push_back(8'h1D);
        do_read("after_reset", 8'h01, 1);
    endtask

    initial begin
        rst_n  = 1'b0;
        sclk   = 1'b0;
        cs_n   = 1'b1;
        mosi   = 1'b0;
        x_data = 12'h000;
        y_data = 12'h000;
        z_data = 12'h000;
        test_reset();
        test_id_read();
        test_xyz_burst();
        test_write();
        test_snapshot();
        test_abort_and_ignore();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
